// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time divide-ratio controller with boundary-aligned ratio changes and graceful start/stop
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 5,
  parameter int DIV_MIN     = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             div_clk_out,
  output logic             tick
);
  typedef enum logic [1:0] {OFF, RUN, PEND} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n, cur_div_n, pending, pending_n;
  logic [CNT_W:0]   h_n;
  logic             xfer, legal, term, err_n, run_n, dco_n, tick_n;
  assign xfer  = cfg_valid && cfg_ready;
  assign legal = xfer && (cfg_div >= CNT_W'(DIV_MIN));
  assign term  = count == cur_div - 1'b1;
  assign err_n = xfer && !legal;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= OFF;
      count       <= '0;
      cur_div     <= CNT_W'(DIV_DEFAULT);
      pending     <= '0;
      cfg_err     <= 1'b0;
      div_clk_out <= 1'b0;
      tick        <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      cur_div     <= cur_div_n;
      pending     <= pending_n;
      cfg_err     <= err_n;
      div_clk_out <= dco_n;
      tick        <= tick_n;
    end
  end
  always_comb begin
    state_n   = state;
    count_n   = count;
    cur_div_n = cur_div;
    pending_n = pending;
    case (state)
      OFF: begin
        cur_div_n = legal ? cfg_div : cur_div;
        state_n   = en ? RUN : OFF;
      end
      RUN: begin
        count_n = term ? '0 : count + 1'b1;
        if (legal) begin
          pending_n = cfg_div;
          state_n   = PEND;
        end else if (term && !en) begin
          state_n = OFF;
        end
      end
      PEND: begin
        count_n = term ? '0 : count + 1'b1;
        if (term) begin
          cur_div_n = pending;
          state_n   = en ? RUN : OFF;
        end
      end
      default: state_n = OFF;
    endcase
  end
  // Registered outputs are derived from next-state values so they line up with count.
  always_comb begin
    cfg_ready = state != PEND;
    busy      = state == PEND;
    run_n     = state_n != OFF;
    h_n       = ({1'b0, cur_div_n} + 1'b1) >> 1;
    dco_n     = run_n && ({1'b0, count_n} < h_n);
    tick_n    = run_n && (count_n == cur_div_n - 1'b1);
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed stimulus with a period-level reference model checked every cycle
module tb_clk_div_ctrl;
  logic       clk_in = 1'b0, rst = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, busy, div_clk_out, tick;
  logic [7:0] cur_div;
  int         n_cmp = 0, n_bad = 0;
  bit         started = 1'b0;
  bit         m_run, m_pv, m_err;
  int         m_div, m_pos, m_pend;

  clk_div_ctrl #(.CNT_W(8), .DIV_DEFAULT(5), .DIV_MIN(2)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .busy(busy), .cur_div(cur_div),
    .div_clk_out(div_clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a running flag, position within the period, and an optional queued ratio.
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_pv <= 1'b0; m_err <= 1'b0;
      m_div <= 5; m_pos <= 0; m_pend <= 0;
    end else begin
      m_err <= cfg_valid && !m_pv && cfg_div < 2;
      if (!m_run) begin
        if (cfg_valid && cfg_div >= 2) m_div <= int'(cfg_div);
        m_run <= en;
        m_pos <= 0;
      end else begin
        m_pos <= (m_pos == m_div - 1) ? 0 : m_pos + 1;
        if (m_pv) begin
          if (m_pos == m_div - 1) begin
            m_div <= m_pend; m_pv <= 1'b0; m_run <= en;
          end
        end else if (cfg_valid && cfg_div >= 2) begin
          m_pend <= int'(cfg_div); m_pv <= 1'b1;
        end else if (m_pos == m_div - 1 && !en) begin
          m_run <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("div_clk_out", int'(div_clk_out), int'(m_run && m_pos < (m_div + 1) / 2));
      chk("tick", int'(tick), int'(m_run && m_pos == m_div - 1));
      chk("cfg_ready", int'(cfg_ready), int'(!m_pv));
      chk("busy", int'(busy), int'(m_pv));
      chk("cur_div", int'(cur_div), m_div);
      chk("cfg_err", int'(cfg_err), int'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic [7:0] d);
    cfg_div = d; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 600) begin step(1); k++; end
    chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!tick && k < 600) begin step(1); k++; end
    chk("tick_timeout", int'(tick), 1);
  endtask

  initial begin
    logic [9:0] seq, tseq;
    logic [7:0] s8;
    logic [5:0] s6;
    int hi, tk, per;
    #1 rst = 1'b1;
    started = 1'b1;
    step(2);
    chk("rst_cur_div", int'(cur_div), 5);
    chk("rst_dco", int'(div_clk_out), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    rst = 1'b0; en = 1'b1;
    // T1: default ratio 5
    for (int i = 0; i < 10; i++) begin
      step(1);
      seq[9-i] = div_clk_out; tseq[9-i] = tick;
    end
    chk("t1_wave", int'(seq), int'(10'b1110011100));
    chk("t1_tick", int'(tseq), int'(10'b0000100001));
    // T2: change to 4 mid-period
    step(2);
    offer(8'd4);
    chk("t2_busy", int'(busy), 1);
    chk("t2_ready", int'(cfg_ready), 0);
    step(3);
    chk("t2_cur_div", int'(cur_div), 4);
    for (int i = 0; i < 8; i++) begin s8[7-i] = div_clk_out; step(1); end
    chk("t2_wave", int'(s8), int'(8'b11001100));
    // T3: illegal ratio rejected
    chk("t3_ready", int'(cfg_ready), 1);
    offer(8'd1);
    chk("t3_err", int'(cfg_err), 1);
    chk("t3_nobusy", int'(busy), 0);
    step(1);
    chk("t3_err_drop", int'(cfg_err), 0);
    chk("t3_cur_div", int'(cur_div), 4);
    // T4: graceful stop and restart at ratio 5
    offer(8'd5);
    wait_idle();
    step(2);
    en = 1'b0;
    step(2);
    chk("t4_last_tick", int'(tick), 1);
    step(1);
    chk("t4_off_dco", int'(div_clk_out), 0);
    step(5);
    chk("t4_off_tick", int'(tick), 0);
    en = 1'b1;
    step(1);
    chk("t4_restart", int'(div_clk_out), 1);
    // T5: reset while a ratio of 7 is pending
    offer(8'd7);
    chk("t5_busy", int'(busy), 1);
    rst = 1'b1; #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_cur", int'(cur_div), 5);
    step(1);
    rst = 1'b0;
    wait_tick();
    step(1);
    per = 1;
    while (!tick && per < 20) begin step(1); per++; end
    chk("t5_period", per, 5);
    // T6: bounds
    offer(8'd2);
    wait_idle();
    for (int i = 0; i < 6; i++) begin s6[5-i] = div_clk_out; step(1); end
    chk("t6_n2_wave", int'(s6), int'(6'b101010));
    offer(8'd255);
    wait_idle();
    hi = 0; tk = 0;
    for (int i = 0; i < 255; i++) begin hi += int'(div_clk_out); tk += int'(tick); step(1); end
    chk("t6_n255_high", hi, 128);
    chk("t6_n255_ticks", tk, 1);
    chk("t6_wrap_dco", int'(div_clk_out), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
